core_pe_hamming_enc: RTL
========================

# core_pe_hamming_enc

Upstream stage of the data-bucket Hamming decoder. Accepts 4-bit destination address plus 4-bit payload words from the processing element and encodes the payload as Hamming(7,4). Emits 11-bit router packets `{addr[3:0], codeword[6:0]}` through a small FIFO with valid/ready flow control. Includes a programmable single-bit error injector so the downstream corrector can be exercised in-system.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the sent-packet counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_addr`  in  4  destination address; goes to packet bits [10:7].
- `in_data`  in  4  payload d[3:0].
- `out_valid`  out  1  packet available.
- `out_ready`  in  1  router accepts the packet.
- `out_pkt`  out  11  encoded packet.
- `inj_period`  in  4  error-injection period; 0 disables injection.
- `inj_pos`  in  3  codeword bit to flip, 0..6; 7 means no flip.
- `pkt_count`  out  CNT_W  packets delivered (out handshakes), wrapping.

## Operation
- Codeword mapping:
  - cw[2]=d0, cw[4]=d1, cw[5]=d2, cw[6]=d3.
  - cw[0]=d0^d1^d3, cw[1]=d0^d2^d3, cw[3]=d1^d2^d3.
- Packet: out_pkt = {in_addr, cw}. Encoding is combinational at the FIFO write port; the FIFO stores 11-bit packets.
- Accept: input handshake when in_valid && in_ready. in_ready = !full. It does not depend on out_ready, so a full FIFO does not take a write in the same cycle as a pop.
- Injection counter `inj_cnt` (4 bits) advances on each input handshake.
  - When inj_period≠0 and inj_cnt==inj_period−1, the written packet has cw[inj_pos] inverted (no change if inj_pos==7), and inj_cnt returns to 0.
  - Otherwise inj_cnt increments.
  - When inj_period==0, inj_cnt holds at 0.
  - If inj_period changes so that inj_cnt ≥ inj_period, the counter wraps to 0 on the next handshake with no flip.
  - Address bits are never corrupted.
- Output: out_valid = !empty; out_pkt = FIFO head. A pop occurs when out_valid && out_ready; pkt_count increments on each pop and wraps at 2^CNT_W.
- Simultaneous push and pop when not full and not empty: occupancy unchanged, order preserved.
- Pointers are log2(DEPTH) bits plus one wrap bit. Full when the indices are equal and the wrap bits differ; empty when both are equal.
- FIFO ordering is strict; no reordering, no drops.

## Timing
- Reset (synchronous, active-high): FIFO empty, so out_valid=0 and in_ready=1. Pointers, inj_cnt and pkt_count are 0. out_pkt is don't-care while out_valid=0 and is driven to 0 after reset.
- Reset asserted mid-operation discards all buffered packets at that edge. No handshakes complete in a cycle where reset is high.
- Latency: a word accepted at edge N is visible on out_pkt with out_valid=1 after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
- Throughput: 1 packet/cycle sustained while out_ready=1.
- out_pkt must stay stable while out_valid=1 and out_ready=0.
- in_ready falls in the cycle after the DEPTH-th unpopped write. It rises in the cycle after a pop from full.

## Structure
- Shared package `core_pe_pkg` holds:
  - localparams ADDR_W=4, DATA_W=4, CW_W=7, PKT_W=11;
  - a `hamming74_encode` function;
  - a packed struct `router_pkt_t` {addr, cw}.
- The decoder side shares the same package.
- One sub-module: `core_pe_fifo` (parameterised width/depth, synchronous, valid/ready).
- The encoder, injector and pkt_count logic live in the top module.

## Test plan
- Reset, then addr=5, data=4'b1011, out_ready=1 → out_pkt=11'h2D5 (cw=7'h55) one cycle after accept; pkt_count=1.
- Encode corners: data=0 → cw=7'h00; data=4'hF → cw=7'h7F; addr=4'hA, data=4'h0 → out_pkt=11'h500.
- Backpressure: out_ready=0, push 5 words with DEPTH=4 → in_ready=0 after the 4th. Then release → packets drain in order, pkt_count=4, and the 5th word is accepted the cycle after the first pop.
- Injection: inj_period=2, inj_pos=2, send addr=5/data=4'b1011 three times → 11'h2D5, 11'h2D1, 11'h2D5. With inj_pos=7 → all 11'h2D5.
- Concurrency: FIFO at occupancy 2, push and pop in the same cycle → occupancy stays 2, order intact. Then assert reset with 3 entries buffered → out_valid=0, in_ready=1, pkt_count=0 next cycle.
- Random: 10k words with random valid/ready. A scoreboard checks every packet against the reference encode plus expected injection, and a software Hamming decode recovers in_data.

Source files
------------

// File: rtl/core_pe_pkg.sv
// Shared types and the Hamming(7,4) encoder for the PE encoder and the data-bucket decoder.
// Combinational helpers only, so there is no latency.
// Stateless, so there is no backpressure.
package core_pe_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int CW_W   = 7;
    localparam int PKT_W  = ADDR_W + CW_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [CW_W-1:0]   cw;
    } router_pkt_t;

    // Data sits at cw[2,4,5,6]; parity at cw[0,1,3] (Hamming positions 1,2,4).
    function automatic logic [CW_W-1:0] hamming74_encode(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] cw;
        cw[2] = d[0];
        cw[4] = d[1];
        cw[5] = d[2];
        cw[6] = d[3];
        cw[0] = d[0] ^ d[1] ^ d[3];
        cw[1] = d[0] ^ d[2] ^ d[3];
        cw[3] = d[1] ^ d[2] ^ d[3];
        return cw;
    endfunction

endpackage

// File: rtl/core_pe_fifo.sv
// Synchronous valid/ready FIFO with wrap-bit pointers.
// Latency: a write at edge N is visible at the head in cycle N+1, no bypass.
// Backpressure: wr_rdy = !full regardless of rd_rdy, so a full FIFO never writes on a pop cycle.
module core_pe_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_vld,
    output logic         wr_rdy,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;

    assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty  = (wr_ptr == rd_ptr);
    assign wr_rdy = !full;
    assign rd_vld = !empty;
    assign push   = wr_vld && !full;
    assign pop    = rd_rdy && !empty;

    // Head is forced to zero when empty so the output is clean right after reset.
    assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/core_pe_hamming_enc.sv
// Hamming(7,4) packet encoder with periodic single-bit error injection and a delivered-packet counter.
// Latency: one cycle from input handshake to out_valid via the internal FIFO.
// Backpressure: in_ready = FIFO not full; out_ready stalls the FIFO head.
module core_pe_hamming_enc
    import core_pe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PKT_W-1:0]  out_pkt,
    input  logic [3:0]        inj_period,
    input  logic [2:0]        inj_pos,
    output logic [CNT_W-1:0]  pkt_count
);

    logic            in_hs;
    logic            out_hs;
    logic            inj_hit;
    logic [3:0]      inj_cnt;
    logic [CW_W-1:0] flip_mask;
    router_pkt_t     wr_pkt;

    assign in_hs   = in_valid && in_ready;
    assign out_hs  = out_valid && out_ready;
    assign inj_hit = (inj_period != 4'd0) && (inj_cnt == inj_period - 4'd1);

    // inj_pos==7 shifts the one past bit 6 and truncates away, giving no flip.
    assign flip_mask = inj_hit ? CW_W'(8'd1 << inj_pos) : '0;

    assign wr_pkt.addr = in_addr;
    assign wr_pkt.cw   = hamming74_encode(in_data) ^ flip_mask;

    core_pe_fifo #(
        .W     (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (in_valid),
        .wr_rdy (in_ready),
        .wr_dat (wr_pkt),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (out_pkt)
    );

    // A shrunken period leaves inj_cnt >= period; >= period-1 folds that case into the wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            inj_cnt <= 4'd0;
        end else if (in_hs) begin
            if (inj_period == 4'd0 || inj_cnt >= inj_period - 4'd1)
                inj_cnt <= 4'd0;
            else
                inj_cnt <= inj_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            pkt_count <= '0;
        else if (out_hs)
            pkt_count <= pkt_count + CNT_W'(1);
    end

endmodule
